// File: rtl/cr_had_pkg.sv
// Shared definitions for the HAD debug-request controller.
// Holds the FSM state encodings, the entry-reason codes and the default counter width.
package cr_had_pkg;

  localparam int CNT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DBG  = 2'b10,
    ST_EXIT = 2'b11
  } had_state_e;

  localparam logic [1:0] REASON_NONE = 2'b00;
  localparam logic [1:0] REASON_BKPT = 2'b01;
  localparam logic [1:0] REASON_HALT = 2'b10;
  localparam logic [1:0] REASON_BOTH = 2'b11;

  function automatic logic [1:0] reason_code(input logic bkpt, input logic halt);
    logic [1:0] code;
    code = REASON_NONE;
    if (bkpt && halt) code = REASON_BOTH;
    else if (bkpt)    code = REASON_BKPT;
    else if (halt)    code = REASON_HALT;
    return code;
  endfunction

endpackage

// File: rtl/cr_had_bkpt_cnt.sv
// Loadable saturating down-counter for breakpoint hit filtering.
// filtered flags a hit that is absorbed by the counter rather than triggering debug entry.
module cr_had_bkpt_cnt
  import cr_had_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 cpuclk,
  input  logic                 hadrst_b,
  input  logic                 idle,
  input  logic                 hit,
  input  logic                 cnt_en,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 filtered,
  output logic [CNT_WIDTH-1:0] cnt_val
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Filtering only happens on a nonzero count, so the decrement can never wrap.
  assign filtered = idle & hit & cnt_en & (cnt_val != '0);

  always_ff @(posedge cpuclk or negedge hadrst_b) begin
    if (!hadrst_b) begin
      cnt_val <= '0;
    end else if (load) begin
      cnt_val <= load_val;
    end else if (filtered) begin
      cnt_val <= cnt_val - CNT_ONE;
    end
  end

endmodule

// File: rtl/cr_had_dbgreq_ctrl.sv
// Debug-request controller: filters breakpoint hits, merges external halt requests,
// and holds the debug-mode request to the core until it reports debug mode.
module cr_had_dbgreq_ctrl
  import cr_had_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 cpuclk,
  input  logic                 hadrst_b,
  input  logic                 bkpt_ctrl_inst_fetch_dbq_req,
  input  logic                 regs_ext_halt_req,
  input  logic                 regs_bkpt_cnt_en,
  input  logic                 regs_bkpt_cnt_wen,
  input  logic [CNT_WIDTH-1:0] regs_bkpt_cnt,
  input  logic                 regs_hit_clr,
  input  logic                 iu_yy_xx_dbgon,
  output logic                 had_core_dbg_mode_req,
  output logic                 ctrl_regs_bkpt_hit,
  output logic [1:0]           ctrl_regs_dbg_reason,
  output logic [CNT_WIDTH-1:0] ctrl_regs_cnt_val
);

  // state | meaning
  // IDLE  | waiting for a breakpoint trigger, halt request or foreign debug entry
  // REQ   | debug-mode request held high until the core reports dbgon
  // DBG   | core in debug mode, all requests ignored
  // EXIT  | one-cycle guard after dbgon drops so a stale hit cannot re-trigger

  had_state_e state;
  logic       is_idle;
  logic       filtered;
  logic       bkpt_trig;
  logic       halt_trig;
  logic       enter_req;

  assign is_idle   = (state == ST_IDLE);
  assign bkpt_trig = is_idle & bkpt_ctrl_inst_fetch_dbq_req & ~filtered;
  assign halt_trig = is_idle & regs_ext_halt_req;
  assign enter_req = ~iu_yy_xx_dbgon & (bkpt_trig | halt_trig);

  cr_had_bkpt_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_bkpt_cnt (
    .cpuclk   (cpuclk),
    .hadrst_b (hadrst_b),
    .idle     (is_idle),
    .hit      (bkpt_ctrl_inst_fetch_dbq_req),
    .cnt_en   (regs_bkpt_cnt_en),
    .load     (regs_bkpt_cnt_wen),
    .load_val (regs_bkpt_cnt),
    .filtered (filtered),
    .cnt_val  (ctrl_regs_cnt_val)
  );

  always_ff @(posedge cpuclk or negedge hadrst_b) begin
    if (!hadrst_b) begin
      state                 <= ST_IDLE;
      had_core_dbg_mode_req <= 1'b0;
      ctrl_regs_dbg_reason  <= REASON_NONE;
      ctrl_regs_bkpt_hit    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Debug entered from elsewhere: follow the core without claiming a reason.
          if (iu_yy_xx_dbgon) begin
            state <= ST_DBG;
          end else if (enter_req) begin
            state                 <= ST_REQ;
            had_core_dbg_mode_req <= 1'b1;
            ctrl_regs_dbg_reason  <= reason_code(bkpt_trig, halt_trig);
          end
        end
        ST_REQ: begin
          if (iu_yy_xx_dbgon) begin
            state                 <= ST_DBG;
            had_core_dbg_mode_req <= 1'b0;
          end
        end
        ST_DBG: begin
          if (!iu_yy_xx_dbgon) state <= ST_EXIT;
        end
        ST_EXIT: begin
          state <= ST_IDLE;
        end
        default: begin
          state                 <= ST_IDLE;
          had_core_dbg_mode_req <= 1'b0;
        end
      endcase

      // A set in the same cycle as a clear wins.
      if (enter_req && bkpt_trig) begin
        ctrl_regs_bkpt_hit <= 1'b1;
      end else if (regs_hit_clr) begin
        ctrl_regs_bkpt_hit <= 1'b0;
      end
    end
  end

endmodule
